// File: rtl/proc_port_arbiter.sv
// proc_port_arbiter
// Round-robin arbiter that shares the single data_in/data_out port pair of
// SimpleProcessor among N_REQ requesters. One word is in flight at a time:
// it is driven onto the processor, the result is captured LAT cycles later
// and returned with the requester ID over a valid/ready response channel.
//
// Optional feature macro: PROC_ARB_PRIO_EN
//   defined   -> requester 0 has strict priority, the others round-robin
//                among themselves and only non-zero grants move 'last'.
//   undefined -> pure round-robin over all requesters.

module proc_port_arbiter #(
    parameter int N_REQ = 4,
    parameter int DW    = 16,
    parameter int LAT   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DW-1:0]       req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [DW-1:0]             proc_data_in,
    input  logic [DW-1:0]             proc_data_out,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DW-1:0]             rsp_data,
    output logic [$clog2(N_REQ)-1:0]  rsp_id,
    output logic                      busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   last;
    logic [CW-1:0]   cnt;
    logic            grant_found;
    logic [IW-1:0]   grant_idx;
    logic [DW-1:0]   grant_word;
    logic [IW:0]     probe;

    // Pick the first valid requester after 'last', wrapping modulo N_REQ; the
    // probe is one bit wider so last+k never overflows before the wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        probe       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            probe = {1'b0, last} + (IW+1)'(k);
            if (probe >= (IW+1)'(N_REQ)) begin
                probe = probe - (IW+1)'(N_REQ);
            end
            if (!grant_found && req_valid[probe[IW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = probe[IW-1:0];
            end
        end
`ifdef PROC_ARB_PRIO_EN
        if (req_valid[0]) begin
            grant_found = 1'b1;
            grant_idx   = '0;
        end
`endif
    end

    // Mux out the data word belonging to the current grant candidate.
    always_comb begin
        grant_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == IW'(i)) begin
                grant_word = req_data[i*DW +: DW];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept, count down the processor latency, then hold the response.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (grant_found) state_next = WAIT;
            WAIT: if (cnt == CW'(1)) state_next = RESP;
            RESP: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Combinational outputs: one-hot accept strobe only in IDLE and never under reset.
    always_comb begin
        req_ready = '0;
        busy      = (state != IDLE);
        if (!rst && state == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Datapath registers: latch the granted word, count latency, capture and release the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            last         <= IW'(N_REQ - 1);
            cnt          <= '0;
            proc_data_in <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_id       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        proc_data_in <= grant_word;
                        rsp_id       <= grant_idx;
                        cnt          <= CW'(LAT);
`ifdef PROC_ARB_PRIO_EN
                        if (grant_idx != '0) begin
                            last <= grant_idx;
                        end
`else
                        last <= grant_idx;
`endif
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        rsp_data  <= proc_data_out;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_proc_port_arbiter.sv
// tb_proc_port_arbiter
// Self-checking bench for proc_port_arbiter: a table of single transactions,
// hand-written multi-cycle sequences (backpressure, reset mid-WAIT, grant
// order under continuous requests, LAT=1 instance) and randomized traffic
// checked against a transaction-level round-robin model.

module tb_proc_port_arbiter;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int LAT = 2;
    localparam int IW  = 2;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic [DW-1:0]     proc_data_in;
    logic [DW-1:0]     proc_data_out;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]     rsp_data;
    logic [IW-1:0]     rsp_id;
    logic              busy;

    logic [1:0]        req_valid1;
    logic [2*DW-1:0]   req_data1;
    logic [1:0]        req_ready1;
    logic [DW-1:0]     proc_data_in1;
    logic [DW-1:0]     proc_data_out1;
    logic              rsp_valid1;
    logic              rsp_ready1;
    logic [DW-1:0]     rsp_data1;
    logic [0:0]        rsp_id1;
    logic              busy1;

    int passCount  = 0;
    int checkCount = 0;
    int modelLast  = N - 1;

    proc_port_arbiter #(.N_REQ(N), .DW(DW), .LAT(LAT)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .proc_data_in  (proc_data_in),
        .proc_data_out (proc_data_out),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_id        (rsp_id),
        .busy          (busy)
    );

    proc_port_arbiter #(.N_REQ(2), .DW(DW), .LAT(1)) u_dut_lat1 (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid1),
        .req_data      (req_data1),
        .req_ready     (req_ready1),
        .proc_data_in  (proc_data_in1),
        .proc_data_out (proc_data_out1),
        .rsp_valid     (rsp_valid1),
        .rsp_ready     (rsp_ready1),
        .rsp_data      (rsp_data1),
        .rsp_id        (rsp_id1),
        .busy          (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Processor model: data_out = data_in + 1, valid LAT cycles after data_in changes.
    logic [DW-1:0] procPipe [0:LAT-1];
    always @(posedge clk) begin
        procPipe[0] <= proc_data_in;
        for (int k = 1; k < LAT; k++) procPipe[k] <= procPipe[k-1];
    end
    generate
        if (LAT == 1) begin : g_lat1
            assign proc_data_out = proc_data_in + 16'd1;
        end else begin : g_latn
            assign proc_data_out = procPipe[LAT-2] + 16'd1;
        end
    endgenerate
    assign proc_data_out1 = proc_data_in1 + 16'd1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic [N-1:0] valid, input logic [N*DW-1:0] data, input logic rready);
        req_valid = valid;
        req_data  = data;
        rsp_ready = rready;
    endtask

    task automatic stepClock();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference rule: first valid requester after 'last', modulo N (requester 0 first when prioritised).
    function automatic int modelPick(input logic [N-1:0] m, input int lastIdx);
`ifdef PROC_ARB_PRIO_EN
        if (m[0]) return 0;
`endif
        for (int k = 1; k <= N; k++) begin
            if (m[(lastIdx + k) % N]) return (lastIdx + k) % N;
        end
        return -1;
    endfunction

    function automatic int modelNextLast(input int g, input int lastIdx);
`ifdef PROC_ARB_PRIO_EN
        if (g == 0) return lastIdx;
`endif
        return g;
    endfunction

    function automatic int onehotIdx(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) if (r[i]) return i;
        return -1;
    endfunction

    task automatic pulseReset();
        rst = 1'b1;
        applyStimulus('0, req_data, 1'b1);
        stepClock();
        stepClock();
        rst = 1'b0;
        modelLast = N - 1;
    endtask

    // Hold a request mask and check every grant's identity and spacing against the model.
    task automatic collectGrants(input logic [N-1:0] m, input int count, input string tag);
        int got = 0;
        int cyc = 0;
        int lastCyc = -1;
        int g;
        int exp;
        applyStimulus(m, req_data, 1'b1);
        while (got < count && cyc < 100) begin
            #1;
            if (req_ready != '0) begin
                g   = onehotIdx(req_ready);
                exp = modelPick(m, modelLast);
                checkOutput({tag, "Grant"}, g, exp);
                if (lastCyc >= 0) checkOutput({tag, "Spacing"}, cyc - lastCyc, LAT + 2);
                lastCyc   = cyc;
                modelLast = modelNextLast(exp, modelLast);
                got++;
            end
            stepClock();
            cyc++;
        end
        checkOutput({tag, "Count"}, got, count);
        applyStimulus('0, req_data, 1'b1);
        for (int k = 0; k < 20 && busy; k++) stepClock();
        checkOutput({tag, "Drained"}, busy, 0);
    endtask

    typedef struct {
        logic [N-1:0]  valid;
        logic [DW-1:0] base;
        int            expId;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [N*DW-1:0] d;
        logic [DW-1:0]   expWord;
        int              g;

`ifdef PROC_ARB_PRIO_EN
        vecs[0] = '{4'b0100, 16'h1232, 2};
        vecs[1] = '{4'b1111, 16'h2000, 0};
        vecs[2] = '{4'b1111, 16'h3000, 0};
        vecs[3] = '{4'b0011, 16'h4000, 0};
        vecs[4] = '{4'b0011, 16'h5000, 0};
        vecs[5] = '{4'b1000, 16'h6000, 3};
        vecs[6] = '{4'b1001, 16'hFFF0, 0};
        vecs[7] = '{4'b0110, 16'h7000, 1};
`else
        vecs[0] = '{4'b0100, 16'h1232, 2};
        vecs[1] = '{4'b1111, 16'h2000, 3};
        vecs[2] = '{4'b1111, 16'h3000, 0};
        vecs[3] = '{4'b0011, 16'h4000, 1};
        vecs[4] = '{4'b0011, 16'h5000, 0};
        vecs[5] = '{4'b1000, 16'h6000, 3};
        vecs[6] = '{4'b1001, 16'hFFF0, 0};
        vecs[7] = '{4'b0110, 16'h7000, 1};
`endif

        // Reset: strobes stay low while reset is held, registers clear.
        rst        = 1'b1;
        req_valid1 = '0;
        req_data1  = '0;
        rsp_ready1 = 1'b1;
        applyStimulus(4'b1111, '0, 1'b0);
        stepClock();
        stepClock();
        #1;
        checkOutput("resetReady", req_ready, 0);
        applyStimulus('0, '0, 1'b1);
        stepClock();
        rst = 1'b0;
        #1;
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetProcIn", proc_data_in, 0);
        checkOutput("resetRspValid", rsp_valid, 0);
        checkOutput("resetRspData", rsp_data, 0);
        checkOutput("resetRspId", rsp_id, 0);
        checkOutput("resetBusyLat1", busy1, 0);

        // Table of single transactions with rsp_ready held high.
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < N; i++) d[i*DW +: DW] = vecs[v].base + DW'(i);
            applyStimulus(vecs[v].valid, d, 1'b1);
            #1;
            checkOutput("vecReady", req_ready, 1 << vecs[v].expId);
            checkOutput("vecIdleBusy", busy, 0);
            stepClock();
            applyStimulus('0, d, 1'b1);
            #1;
            checkOutput("vecProcIn", proc_data_in, vecs[v].base + DW'(vecs[v].expId));
            checkOutput("vecBusy", busy, 1);
            for (int k = 1; k < LAT; k++) begin
                stepClock();
                checkOutput("vecEarlyValid", rsp_valid, 0);
            end
            stepClock();
            expWord = vecs[v].base + DW'(vecs[v].expId) + 16'd1;
            checkOutput("vecRspValid", rsp_valid, 1);
            checkOutput("vecRspData", rsp_data, expWord);
            checkOutput("vecRspId", rsp_id, vecs[v].expId);
            stepClock();
            checkOutput("vecRspClear", rsp_valid, 0);
            checkOutput("vecBusyClear", busy, 0);
            modelLast = modelNextLast(vecs[v].expId, modelLast);
        end

        // Backpressure: response held for 10 cycles, requests ignored, no grant on release edge.
        d = '0;
        d[1*DW +: DW] = 16'hABCD;
        applyStimulus(4'b0010, d, 1'b0);
        #1;
        checkOutput("bpReady", req_ready, 4'b0010);
        stepClock();
        modelLast = modelNextLast(1, modelLast);
        applyStimulus(4'b1111, d, 1'b0);
        for (int k = 0; k < LAT; k++) stepClock();
        for (int k = 0; k < 10; k++) begin
            stepClock();
            checkOutput("bpValid", rsp_valid, 1);
            checkOutput("bpData", rsp_data, 16'hABCE);
            checkOutput("bpId", rsp_id, 1);
            checkOutput("bpBusy", busy, 1);
            checkOutput("bpReadyLow", req_ready, 0);
        end
        rsp_ready = 1'b1;
        stepClock();
        checkOutput("bpReleaseValid", rsp_valid, 0);
        checkOutput("bpReleaseBusy", busy, 0);
        #1;
        checkOutput("bpNextGrant", req_ready, 1 << modelPick(4'b1111, modelLast));
        applyStimulus('0, d, 1'b1);
        stepClock();

        // Reset asserted one cycle after an accept aborts the transaction.
        d[3*DW +: DW] = 16'h5555;
        applyStimulus(4'b1000, d, 1'b1);
        stepClock();
        applyStimulus('0, d, 1'b1);
        stepClock();
        rst = 1'b1;
        applyStimulus(4'b1111, d, 1'b1);
        stepClock();
        #1;
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstProcIn", proc_data_in, 0);
        checkOutput("midRstValid", rsp_valid, 0);
        checkOutput("midRstReady", req_ready, 0);
        rst = 1'b0;
        modelLast = N - 1;
        #1;
        checkOutput("midRstNextGrant", req_ready, 4'b0001);

        // Continuous requests: round-robin order and LAT+2 spacing.
        collectGrants(4'b1111, 5, "all");
        pulseReset();
        collectGrants(4'b0011, 4, "pair");

        // Randomized traffic against the transaction-level model.
        for (int it = 0; it < 40; it++) begin
            logic [N-1:0] m;
            int stall;
            m = N'($urandom);
            for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'($urandom);
            applyStimulus(m, d, 1'b1);
            #1;
            g = modelPick(m, modelLast);
            if (g < 0) begin
                checkOutput("rndIdleReady", req_ready, 0);
                stepClock();
                checkOutput("rndIdleBusy", busy, 0);
            end else begin
                checkOutput("rndReady", req_ready, 1 << g);
                stall = $urandom_range(0, 3);
                stepClock();
                applyStimulus(N'($urandom), d, stall == 0);
                #1;
                checkOutput("rndProcIn", proc_data_in, d[g*DW +: DW]);
                checkOutput("rndWaitReady", req_ready, 0);
                for (int k = 1; k < LAT; k++) begin
                    stepClock();
                    checkOutput("rndEarlyValid", rsp_valid, 0);
                end
                stepClock();
                expWord = d[g*DW +: DW] + 16'd1;
                checkOutput("rndRspValid", rsp_valid, 1);
                checkOutput("rndRspData", rsp_data, expWord);
                checkOutput("rndRspId", rsp_id, g);
                for (int s = 0; s < stall; s++) begin
                    stepClock();
                    checkOutput("rndHoldValid", rsp_valid, 1);
                    checkOutput("rndHoldData", rsp_data, expWord);
                end
                applyStimulus('0, d, 1'b1);
                stepClock();
                checkOutput("rndRelease", rsp_valid, 0);
                checkOutput("rndReleaseBusy", busy, 0);
                modelLast = modelNextLast(g, modelLast);
            end
        end

        // LAT=1 instance: response one edge after the accept.
        req_valid1 = 2'b01;
        req_data1  = {16'h0000, 16'h00FF};
        rsp_ready1 = 1'b1;
        #1;
        checkOutput("lat1Ready", req_ready1, 2'b01);
        stepClock();
        req_valid1 = '0;
        checkOutput("lat1ProcIn", proc_data_in1, 16'h00FF);
        checkOutput("lat1NotYet", rsp_valid1, 0);
        stepClock();
        checkOutput("lat1Valid", rsp_valid1, 1);
        checkOutput("lat1Data", rsp_data1, 16'h0100);
        checkOutput("lat1Id", rsp_id1, 0);
        stepClock();
        checkOutput("lat1Clear", rsp_valid1, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
